// File: rtl/ov7670_capture.sv
// ov7670_capture: OV7670 YUV422 bus to 4-bit grayscale frame buffer writer; define OV7670_CAPTURE_FREEZE_EN to add capture_freeze
module ov7670_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int Y_FIRST  = 1,
  parameter int ADDR_W   = 19
) (
  input  logic              clk24,
  input  logic              rst,
`ifdef OV7670_CAPTURE_FREEZE_EN
  input  logic              capture_freeze,
`endif
  input  logic              cam_pclk,
  input  logic              cam_href,
  input  logic              cam_vsync,
  input  logic [7:0]        cam_data,
  output logic [ADDR_W-1:0] frame_addr,
  output logic [3:0]        frame_pixel,
  output logic              frame_we,
  output logic              frame_start,
  output logic              frame_done,
  output logic              frame_error
);
  typedef enum logic [1:0] {SYNC_WAIT, VBLANK, ACTIVE} state_t;
  localparam logic [10:0] H_MAX = 11'(H_ACTIVE);
  localparam logic [9:0]  V_MAX = 10'(V_ACTIVE);
  state_t            r_state, w_next;
  logic [10:0]       r_s1, r_s2, r_s3;
  logic [2:0]        r_s4;
  logic [10:0]       r_col;
  logic [9:0]        r_row;
  logic [ADDR_W-1:0] r_addr;
  logic              r_phase, r_err;
  logic              w_rise, w_href, w_href_fall, w_vs_rise, w_vs_fall;
  logic              w_ybyte, w_pix_ok, w_start, w_done, w_we_en, w_unused;
  assign w_rise      = r_s3[10] & ~r_s4[2];
  assign w_href      = r_s3[9];
  assign w_href_fall = ~r_s3[9] & r_s4[1];
  assign w_vs_rise   = r_s3[8] & ~r_s4[0];
  assign w_vs_fall   = ~r_s3[8] & r_s4[0];
  assign w_ybyte     = (Y_FIRST != 0) ? ~r_phase : r_phase;
  assign w_pix_ok    = w_ybyte && (r_col < H_MAX) && (r_row < V_MAX);
  assign w_unused    = ^r_s3[3:0];
  // whole bus through identical 2-FF synchronisers, then one aligned stage for edge detection
  always_ff @(posedge clk24)
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
      r_s4 <= '0;
    end else begin
      r_s1 <= {cam_pclk, cam_href, cam_vsync, cam_data};
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      r_s4 <= r_s3[10:8];
    end
  // frame state register
  always_ff @(posedge clk24)
    r_state <= rst ? SYNC_WAIT : w_next;
  // frame sequencing: wait for a full vsync pulse before the first frame
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_done  = 1'b0;
    if (r_state == SYNC_WAIT && r_s3[8]) w_next = VBLANK;
    if (r_state == VBLANK && w_vs_fall) begin
      w_next  = ACTIVE;
      w_start = 1'b1;
    end
    if (r_state == ACTIVE && w_vs_rise) begin
      w_next = VBLANK;
      w_done = 1'b1;
    end
  end
`ifdef OV7670_CAPTURE_FREEZE_EN
  logic r_freeze;
  assign w_we_en = ~r_freeze;
  // freeze request is taken once per frame at its start
  always_ff @(posedge clk24)
    if (rst) r_freeze <= 1'b0;
    else if (w_start) r_freeze <= capture_freeze;
`else
  assign w_we_en = 1'b1;
`endif
  // pixel/line counters and registered buffer write port
  always_ff @(posedge clk24)
    if (rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_addr      <= '0;
      r_phase     <= 1'b0;
      r_err       <= 1'b0;
      frame_addr  <= '0;
      frame_pixel <= '0;
      frame_we    <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_we    <= 1'b0;
      frame_start <= w_start;
      frame_done  <= w_done;
      if (w_done) frame_error <= r_err | (r_row != V_MAX);
      if (w_start) begin
        r_col   <= '0;
        r_row   <= '0;
        r_addr  <= '0;
        r_phase <= 1'b0;
        r_err   <= 1'b0;
      end else if (r_state == ACTIVE && !w_vs_rise) begin
        if (w_href_fall) begin
          r_err   <= r_err | (r_col != H_MAX);
          r_row   <= r_row + {9'd0, ~&r_row};
          r_col   <= '0;
          r_phase <= 1'b0;
        end else if (w_rise && w_href) begin
          r_phase <= ~r_phase;
          if (w_ybyte) r_col <= r_col + {10'd0, ~&r_col};
          if (w_pix_ok) begin
            frame_we    <= w_we_en;
            frame_pixel <= r_s3[7:4];
            frame_addr  <= r_addr;
            r_addr      <= r_addr + 1'b1;
          end
        end
      end
    end
endmodule

// File: tb/tb_ov7670_capture.sv
// tb_ov7670_capture: scoreboard bench for ov7670_capture over three geometries sharing one camera bus
module tb_ov7670_capture;
  typedef struct {int addr; int pix; int cyc;} exp_t;
  logic clk = 0, rst = 1, pclk = 0, href = 0, vsync = 0;
  logic [7:0] data = 0;
`ifdef OV7670_CAPTURE_FREEZE_EN
  logic freeze = 0;
`endif
  logic [18:0] a_addr, b_addr, c_addr, m_addr;
  logic [3:0]  a_pix, b_pix, c_pix, m_pix;
  logic a_we, a_st, a_dn, a_er, b_we, b_st, b_dn, b_er, c_we, c_st, c_dn, c_er;
  logic m_we, m_start, m_done, m_err, prev_we = 0;
  int sel = 0, cyc = 0, n_tests = 0, n_fail = 0, n_start = 0, n_done = 0, last_err = -1;
  int cur_h, cur_v, exp_addr, exp_row;
  bit cur_yf, expect_on;
  exp_t q[$];
  exp_t e;

  ov7670_capture #(.H_ACTIVE(640), .V_ACTIVE(480), .Y_FIRST(1), .ADDR_W(19)) dut_a (
    .clk24(clk), .rst(rst),
`ifdef OV7670_CAPTURE_FREEZE_EN
    .capture_freeze(freeze),
`endif
    .cam_pclk(pclk), .cam_href(href), .cam_vsync(vsync), .cam_data(data),
    .frame_addr(a_addr), .frame_pixel(a_pix), .frame_we(a_we),
    .frame_start(a_st), .frame_done(a_dn), .frame_error(a_er));
  ov7670_capture #(.H_ACTIVE(8), .V_ACTIVE(6), .Y_FIRST(1), .ADDR_W(19)) dut_b (
    .clk24(clk), .rst(rst),
`ifdef OV7670_CAPTURE_FREEZE_EN
    .capture_freeze(freeze),
`endif
    .cam_pclk(pclk), .cam_href(href), .cam_vsync(vsync), .cam_data(data),
    .frame_addr(b_addr), .frame_pixel(b_pix), .frame_we(b_we),
    .frame_start(b_st), .frame_done(b_dn), .frame_error(b_er));
  ov7670_capture #(.H_ACTIVE(4), .V_ACTIVE(1), .Y_FIRST(0), .ADDR_W(19)) dut_c (
    .clk24(clk), .rst(rst),
`ifdef OV7670_CAPTURE_FREEZE_EN
    .capture_freeze(freeze),
`endif
    .cam_pclk(pclk), .cam_href(href), .cam_vsync(vsync), .cam_data(data),
    .frame_addr(c_addr), .frame_pixel(c_pix), .frame_we(c_we),
    .frame_start(c_st), .frame_done(c_dn), .frame_error(c_er));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always_comb begin
    m_addr  = sel == 0 ? a_addr : sel == 1 ? b_addr : c_addr;
    m_pix   = sel == 0 ? a_pix  : sel == 1 ? b_pix  : c_pix;
    m_we    = sel == 0 ? a_we   : sel == 1 ? b_we   : c_we;
    m_start = sel == 0 ? a_st   : sel == 1 ? b_st   : c_st;
    m_done  = sel == 0 ? a_dn   : sel == 1 ? b_dn   : c_dn;
    m_err   = sel == 0 ? a_er   : sel == 1 ? b_er   : c_er;
  end

  // scoreboard: every write of the selected DUT is matched against the next expected one
  always @(negedge clk) begin
    if (m_start) n_start++;
    if (m_done) begin
      n_done++;
      last_err = m_err ? 1 : 0;
    end
    if (m_we) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write got addr=%0d pix=%0h want no write", m_addr, m_pix);
      end else begin
        e = q.pop_front();
        if (m_addr !== 19'(e.addr) || m_pix !== 4'(e.pix) || cyc - e.cyc < 3 || cyc - e.cyc > 5 || prev_we) begin
          n_fail++;
          $display("FAIL write got addr=%0d pix=%0h lat=%0d b2b=%0b want addr=%0d pix=%0h lat=4 b2b=0",
                   m_addr, m_pix, cyc - e.cyc, prev_we, e.addr, e.pix);
        end
      end
    end
    prev_we = m_we;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1; pclk = 0; href = 0; vsync = 0;
    tick(3);
    rst = 0;
    q.delete();
    n_start = 0; n_done = 0; last_err = -1;
    tick(1);
  endtask

  task automatic put_byte(input logic [7:0] d, input bit w, input int a, input int p);
    pclk = 0; data = d; href = 1;
    tick(2);
    if (w) q.push_back('{a, p, cyc});
    pclk = 1;
    tick(2);
  endtask

  task automatic send_line(input int ncols, input int ybase, input int ystep, input bit ab);
    for (int c = 0; c < ncols; c++) begin
      int yi = ybase + c * ystep;
      logic [7:0] y = yi[7:0];
      bit w = expect_on && c < cur_h && exp_row < cur_v;
      if (cur_yf) begin
        put_byte(y, w, exp_addr, int'(y[7:4]));
        put_byte(~y, 0, 0, 0);
      end else begin
        put_byte(~y, 0, 0, 0);
        put_byte(y, w, exp_addr, int'(y[7:4]));
      end
      if (w) exp_addr++;
    end
    pclk = 0;
    if (ab) begin
      vsync = 1;
      tick(8);
      href = 0;
      tick(2);
    end else begin
      href = 0;
      tick(8);
      exp_row++;
    end
  endtask

  task automatic begin_frame();
    vsync = 1;
    tick(8);
    vsync = 0;
    tick(8);
    exp_addr = 0;
    exp_row = 0;
  endtask

  task automatic end_frame();
    vsync = 1;
    tick(8);
  endtask

  task automatic use_dut(input int s, input int h, input int v, input bit yf);
    sel = s; cur_h = h; cur_v = v; cur_yf = yf;
  endtask

  task automatic test_reset();
    use_dut(0, 640, 480, 1);
    do_reset();
    n_tests++;
    if ({m_addr, m_pix, m_we, m_start, m_done, m_err} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %0h want 0", {m_addr, m_pix, m_we, m_start, m_done, m_err});
    end
    expect_on = 0;
    send_line(4, 'h55, 0, 0);
    n_tests++;
    if (n_start != 0) begin n_fail++; $display("FAIL reset_no_start got %0d want 0", n_start); end
    vsync = 1;
    tick(8);
    n_tests++;
    if (n_start != 0) begin n_fail++; $display("FAIL reset_vsync_high_start got %0d want 0", n_start); end
    vsync = 0;
    tick(8);
    n_tests++;
    if (n_start != 1) begin n_fail++; $display("FAIL reset_vsync_fall_start got %0d want 1", n_start); end
  endtask

  task automatic test_full_frame();
    use_dut(1, 8, 6, 1);
    do_reset();
    begin_frame();
    expect_on = 1;
    for (int r = 0; r < 6; r++) send_line(8, 'hA5, 0, 0);
    end_frame();
    n_tests += 4;
    if (q.size() != 0) begin n_fail++; $display("FAIL full_missing_writes got %0d want 0", q.size()); end
    if (n_start != 1) begin n_fail++; $display("FAIL full_start got %0d want 1", n_start); end
    if (n_done != 1) begin n_fail++; $display("FAIL full_done got %0d want 1", n_done); end
    if (last_err != 0) begin n_fail++; $display("FAIL full_error got %0d want 0", last_err); end
  endtask

  task automatic test_uyvy();
    use_dut(2, 4, 1, 0);
    do_reset();
    begin_frame();
    expect_on = 1;
    send_line(4, 'h1F, 'h10, 0);
    end_frame();
    n_tests += 3;
    if (q.size() != 0) begin n_fail++; $display("FAIL uyvy_missing_writes got %0d want 0", q.size()); end
    if (n_done != 1) begin n_fail++; $display("FAIL uyvy_done got %0d want 1", n_done); end
    if (last_err != 0) begin n_fail++; $display("FAIL uyvy_error got %0d want 0", last_err); end
  endtask

  task automatic test_long_short();
    use_dut(0, 640, 480, 1);
    do_reset();
    begin_frame();
    expect_on = 1;
    send_line(650, 'h37, 'h10, 0);
    send_line(630, 'h6C, 'h30, 0);
    end_frame();
    n_tests += 3;
    if (q.size() != 0) begin n_fail++; $display("FAIL vga_missing_writes got %0d want 0", q.size()); end
    if (n_done != 1) begin n_fail++; $display("FAIL vga_done got %0d want 1", n_done); end
    if (last_err != 1) begin n_fail++; $display("FAIL vga_error got %0d want 1", last_err); end
    use_dut(1, 8, 6, 1);
    do_reset();
    begin_frame();
    send_line(10, 'h12, 'h10, 0);
    send_line(6, 'h34, 'h20, 0);
    for (int r = 0; r < 4; r++) send_line(8, 'h5B, 'h10, 0);
    end_frame();
    n_tests += 2;
    if (q.size() != 0) begin n_fail++; $display("FAIL cols_missing_writes got %0d want 0", q.size()); end
    if (last_err != 1) begin n_fail++; $display("FAIL cols_error got %0d want 1", last_err); end
    begin_frame();
    for (int r = 0; r < 7; r++) send_line(8, 'h90 + r, 'h10, 0);
    end_frame();
    n_tests += 3;
    if (q.size() != 0) begin n_fail++; $display("FAIL rows_missing_writes got %0d want 0", q.size()); end
    if (n_done != 2) begin n_fail++; $display("FAIL rows_done got %0d want 2", n_done); end
    if (last_err != 1) begin n_fail++; $display("FAIL rows_error got %0d want 1", last_err); end
  endtask

  task automatic test_abandon();
    use_dut(1, 8, 6, 1);
    do_reset();
    begin_frame();
    expect_on = 1;
    for (int r = 0; r < 6; r++) send_line(8, 'h27, 'h10, 0);
    send_line(3, 'hF0, 0, 1);
    end_frame();
    n_tests += 3;
    if (q.size() != 0) begin n_fail++; $display("FAIL abandon_missing_writes got %0d want 0", q.size()); end
    if (n_done != 1) begin n_fail++; $display("FAIL abandon_done got %0d want 1", n_done); end
    if (last_err != 0) begin n_fail++; $display("FAIL abandon_error got %0d want 0", last_err); end
  endtask

  task automatic test_reset_mid();
    use_dut(1, 8, 6, 1);
    do_reset();
    begin_frame();
    expect_on = 1;
    for (int r = 0; r < 3; r++) send_line(8, 'h48, 'h10, 0);
    do_reset();
    expect_on = 0;
    for (int r = 0; r < 2; r++) send_line(8, 'hC3, 0, 0);
    n_tests++;
    if (n_start != 0) begin n_fail++; $display("FAIL midreset_start got %0d want 0", n_start); end
    begin_frame();
    expect_on = 1;
    for (int r = 0; r < 6; r++) send_line(8, 'h81, 'h10, 0);
    end_frame();
    n_tests += 4;
    if (q.size() != 0) begin n_fail++; $display("FAIL midreset_missing_writes got %0d want 0", q.size()); end
    if (n_start != 1) begin n_fail++; $display("FAIL midreset_restart got %0d want 1", n_start); end
    if (n_done != 1) begin n_fail++; $display("FAIL midreset_done got %0d want 1", n_done); end
    if (last_err != 0) begin n_fail++; $display("FAIL midreset_error got %0d want 0", last_err); end
  endtask

`ifdef OV7670_CAPTURE_FREEZE_EN
  task automatic test_freeze();
    use_dut(1, 8, 6, 1);
    do_reset();
    freeze = 1;
    begin_frame();
    expect_on = 0;
    send_line(8, 'hB7, 0, 0);
    freeze = 0;
    for (int r = 0; r < 5; r++) send_line(8, 'hB7, 0, 0);
    end_frame();
    n_tests += 2;
    if (n_done != 1) begin n_fail++; $display("FAIL freeze_done got %0d want 1", n_done); end
    if (last_err != 0) begin n_fail++; $display("FAIL freeze_error got %0d want 0", last_err); end
    begin_frame();
    expect_on = 1;
    freeze = 1;
    for (int r = 0; r < 6; r++) send_line(8, 'h3D, 'h10, 0);
    end_frame();
    freeze = 0;
    n_tests += 2;
    if (q.size() != 0) begin n_fail++; $display("FAIL unfreeze_missing_writes got %0d want 0", q.size()); end
    if (n_done != 2) begin n_fail++; $display("FAIL unfreeze_done got %0d want 2", n_done); end
  endtask
`endif

  initial begin
    test_reset();
    test_full_frame();
    test_uyvy();
    test_long_short();
    test_abandon();
    test_reset_mid();
`ifdef OV7670_CAPTURE_FREEZE_EN
    test_freeze();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
